// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard/sequencing controller for the 5-stage pipeline (stall, squash, bubble, HLT drain).
// Latency: control outputs are combinational from FSM state and current inputs (zero cycles).
// Backpressure: imem_wait and load-use hold the front end; HALTED holds everything until rst_n.
// Optional perf counters: define PIPE_HAZARD_PERF_CNT_EN to implement stall_cnt/flush_cnt.
module pipe_hazard_ctrl #(
  parameter int REG_ID_W     = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_is_halt,
  input  logic                ex_is_load,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                ex_branch_taken,
  input  logic                imem_wait,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic           halted_q;
  logic           load_use;

  // Load-use: EX load writes a register the ID instruction reads; R0 is never a real dependency.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // Pipeline control decode: priority branch > load-use > imem wait > halt while running.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          // ID holds a wrong-path instruction, so its hazards are irrelevant.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (imem_wait) begin
          // ID moves on to EX; squash IF/ID so the same instruction is not issued twice.
          pc_stall     = 1'b1;
          if_id_flush  = 1'b1;
        end else if (id_is_halt) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      DRAIN: begin
        if (ex_branch_taken) begin
          // An older branch still in EX kills the HLT sitting in ID.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      default: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    endcase
  end

  // Sequencing FSM: RUN -> DRAIN on an accepted HLT, DRAIN -> HALTED once EX/MEM/WB are empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!ex_branch_taken && !load_use && !imem_wait && id_is_halt) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (ex_branch_taken) begin
            state     <= RUN;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
            if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic             run_stall;
  logic             branch_accepted;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign run_stall       = (state == RUN) && pc_stall;
  assign branch_accepted = ex_branch_taken && ((state == RUN) || (state == DRAIN));

  // Saturating performance counters: RUN-state stall cycles and accepted branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run_stall && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (branch_accepted && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: self-checking bench for pipe_hazard_ctrl (vector table plus multi-cycle sequences).
// Latency: inputs driven 1 ns after posedge, outputs compared on the following negedge.
// Backpressure: none; every step is a fixed cycle, so the run always terminates.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl bit order: [4]=pc_stall [3]=if_id_stall [2]=if_id_flush [1]=id_ex_bubble [0]=halted
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_BR    = 5'b00110;
  localparam logic [4:0] C_WAIT  = 5'b10100;
  localparam logic [4:0] C_HALT  = 5'b11011;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_is_halt, ex_is_load, ex_branch_taken, imem_wait;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, halted;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_ID_W(4), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_halt      (id_is_halt),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_wait       (imem_wait),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
    logic       urs;
    logic       urt;
    logic       hlt;
    logic       ld;
    logic       br;
    logic       iw;
    logic [4:0] ctl;
  } vec_t;

  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vt[12];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_stall  = 16'd0;
  logic [15:0] m_flush  = 16'd0;

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, id, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; ex_rd = v.rd;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_is_halt = v.hlt;
    ex_is_load = v.ld; ex_branch_taken = v.br; imem_wait = v.iw;
  endtask

  // One clock: drive, push expectation, compare at negedge, advance to posedge+1.
  task automatic step(input vec_t v, input bit in_run, input int id);
    exp_t e;
    exp_t got;
    drive(v);
    e.ctl = v.ctl;
    e.sc  = PERF ? m_stall : 16'd0;
    e.fc  = PERF ? m_flush : 16'd0;
    e.id  = id;
    exp_q.push_back(e);
    if (in_run && v.ctl[4] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (v.ctl[2] && v.ctl[1] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty step=%0d actual=0 required=1", id);
    end else begin
      got = exp_q.pop_front();
      chk("pc_stall",     got.id, {15'd0, pc_stall},     {15'd0, got.ctl[4]});
      chk("if_id_stall",  got.id, {15'd0, if_id_stall},  {15'd0, got.ctl[3]});
      chk("if_id_flush",  got.id, {15'd0, if_id_flush},  {15'd0, got.ctl[2]});
      chk("id_ex_bubble", got.id, {15'd0, id_ex_bubble}, {15'd0, got.ctl[1]});
      chk("halted",       got.id, {15'd0, halted},       {15'd0, got.ctl[0]});
      chk("stall_cnt",    got.id, stall_cnt, got.sc);
      chk("flush_cnt",    got.id, flush_cnt, got.fc);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic hlt, input logic br, input logic iw, input logic [4:0] ctl);
    vec_t v;
    v.rs = 4'd1; v.rt = 4'd2; v.rd = 4'd7;
    v.urs = 1'b1; v.urt = 1'b1; v.ld = 1'b0;
    v.hlt = hlt; v.br = br; v.iw = iw; v.ctl = ctl;
    return v;
  endfunction

  // Asynchronous reset pulse placed mid-cycle; checks the immediate effect before any clock edge.
  task automatic async_reset(input int id);
    drive(mk(1'b0, 1'b0, 1'b0, C_NONE));
    #2;
    rst_n = 1'b0;
    #1;
    m_stall = 16'd0;
    m_flush = 16'd0;
    chk("rst_halted",   id, {15'd0, halted},      16'd0);
    chk("rst_pc_stall", id, {15'd0, pc_stall},    16'd0);
    chk("rst_if_stall", id, {15'd0, if_id_stall}, 16'd0);
    chk("rst_stall_cnt", id, stall_cnt, 16'd0);
    chk("rst_flush_cnt", id, flush_cnt, 16'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs, rt, rd, urs, urt, hlt, ld, br, iw, expected
    vt[0]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[1]  = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL};
    vt[2]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE};
    vt[3]  = '{4'd1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL};
    vt[4]  = '{4'd1, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE};
    vt[5]  = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[6]  = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_BR};
    vt[7]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_WAIT};
    vt[8]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_WAIT};
    vt[9]  = '{4'd9, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_STALL};
    vt[10] = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, C_BR};
    vt[11] = '{4'd6, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE};

    rst_n = 1'b0;
    drive(vt[0]);
    #3;
    chk("reset_halted",    0, {15'd0, halted},   16'd0);
    chk("reset_pc_stall",  0, {15'd0, pc_stall}, 16'd0);
    chk("reset_stall_cnt", 0, stall_cnt, 16'd0);
    chk("reset_flush_cnt", 0, flush_cnt, 16'd0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle RUN decode vectors; none of them leaves RUN.
    for (int i = 0; i < 12; i++) step(vt[i], 1'b1, i);

    // imem_wait held four cycles.
    for (int i = 0; i < 4; i++) step(mk(1'b0, 1'b0, 1'b1, C_WAIT), 1'b1, 100 + i);
    step(mk(1'b0, 1'b0, 1'b0, C_NONE), 1'b1, 104);

    // HLT: detect, three drain cycles, then halted holds against any input.
    step(mk(1'b1, 1'b0, 1'b0, C_STALL), 1'b1, 200);
    for (int i = 0; i < 3; i++) step(mk(1'b1, 1'b0, i[0], C_STALL), 1'b0, 201 + i);
    for (int i = 0; i < 22; i++) begin
      vec_t v;
      v = mk(i[1], i[0], i[2], C_HALT);
      v.ld = 1'b1; v.rd = 4'd1;
      step(v, 1'b0, 210 + i);
    end

    // Reset while halted.
    async_reset(300);
    step(mk(1'b0, 1'b0, 1'b0, C_NONE), 1'b1, 301);

    // HLT squashed by an older branch on the first drain cycle.
    step(mk(1'b1, 1'b0, 1'b0, C_STALL), 1'b1, 400);
    step(mk(1'b1, 1'b1, 1'b0, C_BR), 1'b0, 401);
    for (int i = 0; i < 5; i++) step(mk(1'b0, 1'b0, 1'b0, C_NONE), 1'b1, 402 + i);

    // Branch squashing HLT on the last drain cycle also returns to RUN.
    step(mk(1'b1, 1'b0, 1'b0, C_STALL), 1'b1, 500);
    step(mk(1'b0, 1'b0, 1'b0, C_STALL), 1'b0, 501);
    step(mk(1'b0, 1'b0, 1'b0, C_STALL), 1'b0, 502);
    step(mk(1'b0, 1'b1, 1'b0, C_BR), 1'b0, 503);
    for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, C_NONE), 1'b1, 504 + i);

    // Reset in the middle of a drain, then a clean halt afterwards.
    step(mk(1'b1, 1'b0, 1'b0, C_STALL), 1'b1, 600);
    step(mk(1'b0, 1'b0, 1'b0, C_STALL), 1'b0, 601);
    async_reset(602);
    step(mk(1'b0, 1'b0, 1'b0, C_NONE), 1'b1, 603);
    step(mk(1'b1, 1'b0, 1'b0, C_STALL), 1'b1, 604);
    for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, C_STALL), 1'b0, 605 + i);
    step(mk(1'b0, 1'b1, 1'b1, C_HALT), 1'b0, 608);
    async_reset(609);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    // Stall counter saturation at all-ones.
    for (int i = 0; i < 65540; i++) step(mk(1'b0, 1'b0, 1'b1, C_WAIT), 1'b1, 700);
    chk("stall_cnt_sat", 701, stall_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
